// File: rtl/auto_counter_checker.sv
//==============================================================================
// Module      : auto_counter_checker
// Description : Watches a free-running 0-9 decade counter (q_in) and checks
//               that it advances by exactly one, modulo 10, on each step.
//               It locks onto the sequence, flags faults with a one-cycle
//               pulse, keeps a saturating fault count, and counts 9->0 wraps.
//               With CHECKER_PERIOD_CHECK_EN defined, it also checks that
//               steps arrive every TICK_CYCLES +/- TOL_CYCLES clocks and
//               flags a stall when the counter stops moving.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Configuration macro:
//   CHECKER_PERIOD_CHECK_EN : builds the period counter and enables the
//                             period-window and stall checks.
//                             Undefined: only value faults are checked.
//------------------------------------------------------------------------------
// Parameters:
//   TICK_CYCLES : clk cycles between legal counter steps
//   TOL_CYCLES  : allowed +/- deviation of the step period
// Ports:
//   clk        in   1  single clock, rising edge
//   reset      in   1  asynchronous reset, active low
//   q_in       in   4  observed counter value, synchronous to clk
//   clear      in   1  synchronous clear of statistics plus resync request
//   locked     out  1  high while tracking a valid sequence
//   seq_err    out  1  one-cycle pulse per detected fault
//   err_count  out  8  saturating fault count
//   wrap_count out  8  count of accepted 9->0 steps, modulo 256
//   digit      out  4  last accepted counter value
//==============================================================================
`default_nettype none

module auto_counter_checker #(
    parameter int unsigned TICK_CYCLES = 50_000_000,
    parameter int unsigned TOL_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] q_in,
    input  logic       clear,
    output logic       locked,
    output logic       seq_err,
    output logic [7:0] err_count,
    output logic [7:0] wrap_count,
    output logic [3:0] digit
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_TRACK = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    // Two-stage sample of the observed counter: q_s is the current sample,
    // q_p the one before. A step is any difference between the two, so every
    // decision is made one cycle after q_in is first sampled.
    logic [3:0] r_q_s;
    logic [3:0] r_q_p;

    logic       r_seq_err;
    logic [7:0] r_err_count;
    logic [7:0] r_wrap_count;
    logic [3:0] r_digit;

    logic       w_seq_err_nxt;
    logic [7:0] w_err_count_nxt;
    logic [7:0] w_wrap_count_nxt;
    logic [3:0] w_digit_nxt;
    logic       w_fault;

    logic       w_step;
    logic [4:0] w_sum;
    logic [3:0] w_expect;
    logic       w_value_ok;
    logic       w_is_wrap;
    logic       w_period_bad;
    logic       w_stall;

    assign w_step = (r_q_s != r_q_p);

    // (q_p + 1) mod 10 over the full 4-bit input range; values above 9 in
    // q_p still give a defined successor, and q_s > 9 is rejected separately.
    assign w_sum      = {1'b0, r_q_p} + 5'd1;
    assign w_expect   = (w_sum >= 5'd10) ? 4'(w_sum - 5'd10) : w_sum[3:0];
    assign w_value_ok = (r_q_s <= 4'd9) && (r_q_s == w_expect);
    assign w_is_wrap  = (r_q_p == 4'd9) && (r_q_s == 4'd0);

`ifdef CHECKER_PERIOD_CHECK_EN
    localparam int unsigned C_STALL_LIMIT = TICK_CYCLES + TOL_CYCLES + 1;
    localparam int unsigned C_PERIOD_W    = $clog2(TICK_CYCLES + TOL_CYCLES + 2);
    localparam logic [C_PERIOD_W-1:0] C_LIMIT = C_PERIOD_W'(C_STALL_LIMIT);
    localparam logic [C_PERIOD_W-1:0] C_MIN   = C_PERIOD_W'(TICK_CYCLES - TOL_CYCLES);
    localparam logic [C_PERIOD_W-1:0] C_MAX   = C_PERIOD_W'(TICK_CYCLES + TOL_CYCLES);

    logic [C_PERIOD_W-1:0] r_period;
    logic [C_PERIOD_W-1:0] w_elapsed;
    logic                  w_period_clr;

    // r_period is cleared on the accepting edge, so at the edge that
    // evaluates the next step it holds (period - 1); w_elapsed is the period.
    assign w_elapsed    = (r_period == C_LIMIT) ? C_LIMIT : r_period + 1'b1;
    assign w_period_bad = (w_elapsed < C_MIN) || (w_elapsed > C_MAX);
    assign w_stall      = (w_elapsed == C_LIMIT);

    // Outside TRACK the counter idles at zero. Inside TRACK any step either
    // is accepted (restart timing) or faults (leave TRACK), so both clear it.
    assign w_period_clr = (r_state != S_TRACK) || clear || w_step;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_period <= '0;
        end else if (w_period_clr) begin
            r_period <= '0;
        end else begin
            r_period <= w_elapsed;
        end
    end
`else
    assign w_period_bad = 1'b0;
    assign w_stall      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and statistics update
    always_comb begin
        w_state_nxt      = r_state;
        w_seq_err_nxt    = 1'b0;
        w_err_count_nxt  = r_err_count;
        w_wrap_count_nxt = r_wrap_count;
        w_digit_nxt      = r_digit;
        w_fault          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_SYNC;
            end
            S_SYNC: begin
                // Non-incrementing steps are simply ignored while searching.
                if (w_step && w_value_ok) begin
                    w_state_nxt = S_TRACK;
                    w_digit_nxt = r_q_s;
                end
            end
            S_TRACK: begin
                if (w_step) begin
                    if (!w_value_ok || w_period_bad) begin
                        w_fault = 1'b1;
                    end else begin
                        w_digit_nxt = r_q_s;
                        if (w_is_wrap) begin
                            w_wrap_count_nxt = r_wrap_count + 8'd1;
                        end
                    end
                end else if (w_stall) begin
                    w_fault = 1'b1;
                end
            end
            S_FAULT: begin
                w_state_nxt = S_SYNC;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_fault) begin
            w_state_nxt     = S_FAULT;
            w_seq_err_nxt   = 1'b1;
            w_err_count_nxt = (r_err_count == 8'hFF) ? 8'hFF : r_err_count + 8'd1;
        end

        // Clear overrides anything decided above in the same cycle.
        if (clear) begin
            w_state_nxt      = S_SYNC;
            w_seq_err_nxt    = 1'b0;
            w_err_count_nxt  = 8'd0;
            w_wrap_count_nxt = 8'd0;
            w_digit_nxt      = r_digit;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q_s        <= 4'd0;
            r_q_p        <= 4'd0;
            r_seq_err    <= 1'b0;
            r_err_count  <= 8'd0;
            r_wrap_count <= 8'd0;
            r_digit      <= 4'd0;
        end else begin
            r_q_s        <= q_in;
            r_q_p        <= r_q_s;
            r_seq_err    <= w_seq_err_nxt;
            r_err_count  <= w_err_count_nxt;
            r_wrap_count <= w_wrap_count_nxt;
            r_digit      <= w_digit_nxt;
        end
    end

    assign locked     = (r_state == S_TRACK);
    assign seq_err    = r_seq_err;
    assign err_count  = r_err_count;
    assign wrap_count = r_wrap_count;
    assign digit      = r_digit;

endmodule

`default_nettype wire
